// File: rtl/design1_pkg.sv
// Shared types and constants for the design1 memory self-test: state encoding,
// default geometry/seed and the LFSR step function.
package design1_pkg;

  localparam int         DEFAULT_DEPTH = 16;
  localparam int         DEFAULT_WIDTH = 8;
  localparam logic [7:0] DEFAULT_SEED  = 8'h01;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Fibonacci shift-left, taps 7/5/4/3 (maximal length for 8 bits)
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/simple_dp_ram.sv
// DEPTH x WIDTH RAM: one synchronous write port, one read port with a
// single cycle of registered latency. Storage array is not reset.
module simple_dp_ram
  import design1_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_r = {WIDTH{1'b0}};

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (re) begin
      rd_data_r <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/design1_wrapper.sv
// Power-on memory self-test: fill the RAM from an LFSR, read it back against a
// regenerated sequence, then hold a sticky pass/fail result plus a heartbeat.
module design1_wrapper
  import design1_pkg::*;
#(
  parameter int               DEPTH  = DEFAULT_DEPTH,
  parameter int               WIDTH  = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] SEED   = DEFAULT_SEED,
  parameter int               HB_DIV = 8
) (
  input  logic                   sys_clock,
  input  logic                   reset_rtl,
  output logic                   done,
  output logic                   pass,
  output logic [$clog2(DEPTH):0] err_count,
  output logic [1:0]             phase,
  output logic                   heartbeat
);

  localparam int             AW        = $clog2(DEPTH);
  localparam int             CW        = AW + 1;
  localparam int             HW        = $clog2(HB_DIV + 1);
  localparam logic [AW-1:0]  ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0]  ERR_MAX   = {CW{1'b1}};
  localparam logic [HW-1:0]  HB_TOP    = HW'(HB_DIV);

  // Declaration values make the test run from power-up without any reset pulse.
  state_e           state_r      = INIT;
  state_e           state_s;
  logic [AW-1:0]    addr_r       = {AW{1'b0}};
  logic [WIDTH-1:0] lfsr_r       = SEED;
  logic             issued_all_r = 1'b0;
  logic             cmp_valid_r  = 1'b0;
  logic             cmp_last_r   = 1'b0;
  logic             done_r       = 1'b0;
  logic             pass_r       = 1'b0;
  logic [CW-1:0]    err_r        = {CW{1'b0}};
  logic             hb_r         = 1'b0;
  logic [HW-1:0]    hb_cnt_r     = {HW{1'b0}};

  logic             ram_we_s;
  logic             rd_en_s;
  logic             mismatch_s;
  logic [WIDTH-1:0] rd_data_s;

  assign ram_we_s   = (state_r == WRITE);
  assign rd_en_s    = (state_r == READ) && !issued_all_r;
  assign mismatch_s = cmp_valid_r && (rd_data_s != lfsr_r);

  simple_dp_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
    .clk     (sys_clock),
    .we      (ram_we_s),
    .wr_addr (addr_r),
    .wr_data (lfsr_r),
    .re      (rd_en_s),
    .rd_addr (addr_r),
    .rd_data (rd_data_s)
  );

  // next-state logic; READ ends only after the compare of the last issued address
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT:    state_s = WRITE;
      WRITE:   if (addr_r == ADDR_LAST) state_s = READ; else state_s = WRITE;
      READ:    if (cmp_valid_r && cmp_last_r) state_s = DONE; else state_s = READ;
      DONE:    state_s = DONE;
      default: state_s = INIT;
    endcase
  end

  // state register
  always_ff @(posedge sys_clock) begin
    if (reset_rtl) state_r <= INIT;
    else           state_r <= state_s;
  end

  // address counter, LFSR, read pipeline, comparator and result latch
  always_ff @(posedge sys_clock) begin
    if (reset_rtl) begin
      addr_r       <= {AW{1'b0}};
      lfsr_r       <= SEED;
      issued_all_r <= 1'b0;
      cmp_valid_r  <= 1'b0;
      cmp_last_r   <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_r        <= {CW{1'b0}};
    end else begin
      case (state_r)
        WRITE: begin
          addr_r <= addr_r + AW'(1);
          if (addr_r == ADDR_LAST) lfsr_r <= SEED;
          else                     lfsr_r <= lfsr_next(lfsr_r);
        end
        READ: begin
          if (rd_en_s) begin
            addr_r       <= addr_r + AW'(1);
            issued_all_r <= (addr_r == ADDR_LAST);
          end
          cmp_valid_r <= rd_en_s;
          cmp_last_r  <= rd_en_s && (addr_r == ADDR_LAST);
          if (cmp_valid_r) lfsr_r <= lfsr_next(lfsr_r);
          if (mismatch_s && (err_r != ERR_MAX)) err_r <= err_r + CW'(1);
        end
        DONE: begin
          done_r <= 1'b1;
          pass_r <= (err_r == {CW{1'b0}});
        end
        default: begin
          cmp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // heartbeat divider counts 1..HB_DIV so the first toggle lands HB_DIV edges after release
  always_ff @(posedge sys_clock) begin
    if (reset_rtl) begin
      hb_cnt_r <= {HW{1'b0}};
      hb_r     <= 1'b0;
    end else if (hb_cnt_r == HB_TOP) begin
      hb_cnt_r <= HW'(1);
      hb_r     <= ~hb_r;
    end else begin
      hb_cnt_r <= hb_cnt_r + HW'(1);
    end
  end

  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
  assign phase     = state_r;
  assign heartbeat = hb_r;

endmodule

// File: tb/tb_design1_wrapper.sv
// Randomized run-level bench for design1_wrapper: a stimulus process launches
// self-test runs and queues expected results; a monitor compares every cycle.
module tb_design1_wrapper;

  localparam int DEPTH     = 16;
  localparam int WIDTH     = 8;
  localparam int HB_DIV    = 8;
  localparam int DONE_EDGE = 2 * DEPTH + 2;

  logic       sys_clock = 1'b0;
  logic       reset_rtl = 1'b0;
  logic       done, pass, heartbeat;
  logic [4:0] err_count;
  logic [1:0] phase;

  design1_wrapper #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEED(8'h01), .HB_DIV(HB_DIV)) dut (
    .sys_clock (sys_clock),
    .reset_rtl (reset_rtl),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .phase     (phase),
    .heartbeat (heartbeat)
  );

  always #10 sys_clock = ~sys_clock;

  typedef struct {
    int exp_pass;
    int exp_errs;
  } result_t;

  result_t exp_q[$];
  int      checks   = 0;
  int      failures = 0;
  int      edge_k   = -1;
  int      seq [DEPTH];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, edge_k, $time);
    end
  endtask

  // reference LFSR step: shift left by doubling, feedback = parity of taps 7,5,4,3
  function automatic int model_next(input int v);
    int taps;
    taps = v & 32'hB8;
    return ((v * 2) % 256) + ($countones(taps) % 2);
  endfunction

  function automatic int exp_phase(input int k);
    if (k < 0)             return 0;
    if (k < DEPTH)         return 1;
    if (k < 2 * DEPTH + 1) return 2;
    return 3;
  endfunction

  // edges since reset release; -1 after any edge that sampled reset
  always @(posedge sys_clock) begin
    if (reset_rtl) edge_k <= -1;
    else           edge_k <= edge_k + 1;
  end

  // monitor: per-cycle protocol checks plus scoreboard pop when done rises
  initial begin
    int      prev_done;
    int      have_res;
    result_t cur;
    prev_done = 0;
    have_res  = 0;
    cur       = '{0, 0};
    forever begin
      @(negedge sys_clock);
      check("no_x", int'($isunknown({done, pass, err_count, phase, heartbeat})), 0);
      check("phase", int'(phase), exp_phase(edge_k));
      check("done", int'(done), int'(edge_k >= DONE_EDGE));
      check("heartbeat", int'(heartbeat), (edge_k < 0) ? 0 : (edge_k / HB_DIV) % 2);
      if (edge_k >= DEPTH) check("no_write_after_fill", int'(dut.ram_we_s), 0);
      if (edge_k < 0) begin
        check("reset_pass", int'(pass), 0);
        check("reset_err", int'(err_count), 0);
      end
      if (done && prev_done == 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          cur      = exp_q.pop_front();
          have_res = 1;
          for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ram[%0d]", i), int'(dut.u_ram.mem[i]), seq[i]);
          end
        end
      end
      if (done && have_res != 0) begin
        check("pass", int'(pass), cur.exp_pass);
        check("err_count", int'(err_count), cur.exp_errs);
      end
      prev_done = int'(done);
    end
  end

  // stimulus: power-up run, then randomized clean / fault-injected / aborted runs
  initial begin
    int v;
    int mode;
    int pulse;
    int a;
    int errs;
    v = 1;
    for (int i = 0; i < DEPTH; i++) begin
      seq[i] = v;
      v = model_next(v);
    end

    exp_q.push_back('{1, 0});
    repeat (DONE_EDGE + 1 + 200) @(negedge sys_clock);

    for (int run = 0; run < 9; run++) begin
      mode  = (run < 3) ? run : int'($urandom_range(0, 2));
      pulse = (run == 0) ? 5 : int'($urandom_range(1, 5));
      reset_rtl = 1'b1;
      repeat (pulse) @(negedge sys_clock);
      reset_rtl = 1'b0;
      case (mode)
        1: begin
          a    = int'($urandom_range(0, DEPTH - 1));
          errs = (seq[a] != 8'hFF) ? 1 : 0;
          exp_q.push_back('{(errs == 0) ? 1 : 0, errs});
          repeat (DEPTH + 2 + a) @(negedge sys_clock);
          force dut.rd_data_s = 8'hFF;
          @(negedge sys_clock);
          release dut.rd_data_s;
          repeat (DONE_EDGE - DEPTH - 1 - a + 2) @(negedge sys_clock);
        end
        2: begin
          a = (run == 2) ? 7 : int'($urandom_range(1, DONE_EDGE - 1));
          exp_q.push_back('{1, 0});
          repeat (a) @(negedge sys_clock);
          reset_rtl = 1'b1;
          void'(exp_q.pop_back());
          @(negedge sys_clock);
          reset_rtl = 1'b0;
          exp_q.push_back('{1, 0});
          repeat (DONE_EDGE + 1 + 2) @(negedge sys_clock);
        end
        default: begin
          exp_q.push_back('{1, 0});
          repeat (DONE_EDGE + 1 + 2 + int'($urandom_range(0, 20))) @(negedge sys_clock);
        end
      endcase
    end

    repeat (2) @(negedge sys_clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/design1_wrapper.md
# design1_wrapper

Top-level self-test subsystem for the lab board. It runs from a single system clock and reset, with no functional inputs. After reset it fills a 16×8 on-chip RAM with a pseudo-random byte sequence, reads the RAM back and checks each byte against a regenerated sequence. It then holds a sticky pass/fail result. Status outputs exist for observation only; the block must also run correctly when they are left unconnected.

## Interface
Parameters:
- DEPTH, 16, RAM words (power of two, ≥2)
- WIDTH, 8, RAM word width; LFSR width equals WIDTH
- SEED, 8'h01, LFSR seed (non-zero)
- HB_DIV, 8, heartbeat toggles every HB_DIV cycles

Ports (one clock; reset is synchronous and active-high):
- sys_clock  in  1  system clock, 50 MHz nominal, rising-edge
- reset_rtl  in  1  synchronous active-high reset
- done  out  1  self-test complete (sticky)
- pass  out  1  valid when done; 1 = zero mismatches
- err_count  out  $clog2(DEPTH)+1  mismatch count, saturating
- phase  out  2  current state encoding
- heartbeat  out  1  free-running toggle

## Operation
- Every register has a power-up initial value equal to its reset value. The test therefore runs even if reset_rtl is never asserted.
- Reset values: state INIT, addr 0, lfsr SEED, done 0, pass 0, err_count 0, heartbeat 0, heartbeat divider 0.
- LFSR: Fibonacci shift-left. next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. The first values from 0x01 are 01, 02, 04, 08, 11, 23.
- FSM states and phase encoding: INIT=0, WRITE=1, READ=2, DONE=3.
- INIT: lasts 1 cycle, then goes to WRITE.
- WRITE: writes RAM[addr] = lfsr, then advances lfsr and increments addr. After addr DEPTH-1, addr wraps to 0, lfsr reloads SEED, and the state goes to READ.
- READ: issues a read of addr on each of DEPTH cycles. One cycle later it compares the returned data with lfsr, then advances lfsr.
  - A mismatch increments err_count, saturating at its maximum.
  - After the last compare, the state goes to DONE.
- DONE: sets done=1 and pass=(err_count==0). The state holds until reset; there is no automatic rerun.
- heartbeat toggles every HB_DIV cycles in every state. It is cleared only by reset.
- Reset asserted mid-operation: all state returns to reset values on that edge. The full test restarts after reset is released.

## Timing
- Edge 0 is the first rising edge with reset_rtl=0 after reset; the state is INIT during that cycle.
- The WRITE phase covers cycles 1..DEPTH.
- READ issues addresses on cycles DEPTH+1..2·DEPTH. Compares happen one cycle after each issue, on cycles DEPTH+2..2·DEPTH+1.
- done and pass become visible after edge 2·DEPTH+2, which is edge 34 for DEPTH=16 (680 ns at 50 MHz).
- RAM: synchronous write; synchronous read with 1-cycle latency. Read-during-write never occurs.
- All outputs are registered.

## Structure
- Shared package design1_pkg holds:
  - the state enum INIT/WRITE/READ/DONE with its 2-bit encoding
  - the LFSR tap function
  - default SEED, DEPTH and WIDTH
- One sub-module, simple_dp_ram: DEPTH×WIDTH, one write port, one registered read port, no reset on the storage array.
- The FSM, LFSR, address counter, comparator and heartbeat divider live in the top level.

## Test plan
- Power-up with reset_rtl held 0 from time 0 at 20 ns period:
  - before edge 34: done=0
  - at edge 34: done=1, pass=1, err_count=0
  - no X on any output after time 0
- Reset pulse of 5 cycles, then release: phase=0 during reset; WRITE writes RAM[0..5] = 01, 02, 04, 08, 11, 23; pass=1 at the end.
- Force RAM[4] to 0xFF during READ (hierarchical force) → done=1, pass=0, err_count=1.
- Assert reset_rtl at WRITE addr=7 for 1 cycle → outputs return to reset values; the rerun completes 35 edges later with pass=1.
- Heartbeat: toggles every 8 edges from reset release (transitions at edges 8, 16, 24, …) and continues in DONE.
- Hold 200 cycles after done → done, pass and phase=3 stay stable; no further RAM writes.
